// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: one-hot opcodes, FSM state encoding and a popcount helper.
package seq_alu_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_MUL  = 6'b000100;
    localparam logic [5:0] OP_ONES = 6'b001000;
    localparam logic [5:0] OP_XOR  = 6'b010000;
    localparam logic [5:0] OP_MAX  = 6'b100000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counts set bits of a 64-bit vector; callers zero-extend narrower operands.
    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = 7'd0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: loads on start, consumes one multiplier bit per cycle for WIDTH cycles.
module seq_alu_mul
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] addend_s;

    // product is the accumulator after the current step, so the final value is usable in the done cycle.
    always_comb begin
        addend_s = mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}};
        product  = acc_r + addend_s;
        done     = (cnt_r == CNT_W'(1));
    end

    // Load on start, then shift multiplicand left / multiplier right once per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r  <= {(2*WIDTH){1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (start) begin
            mcand_r  <= {{WIDTH{1'b0}}, a};
            acc_r    <= {(2*WIDTH){1'b0}};
            mplier_r <= b;
            cnt_r    <= CNT_W'(WIDTH);
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            acc_r    <= product;
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r - CNT_W'(1);
        end else begin
            acc_r    <= acc_r;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Clocked one-hot ALU with valid/ready handshakes and an iterative multiplier.
// Optional SEQ_ALU_ERR_EN adds an err output flagging non-one-hot control words.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [5:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             equality,
    output logic             balance
`ifdef SEQ_ALU_ERR_EN
    ,
    output logic             err
`endif
);

    if (OUT_W < 2 * WIDTH) begin : g_bad_out_w
        $error("seq_alu: OUT_W must be at least 2*WIDTH");
    end
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("seq_alu: WIDTH must lie in 2..32");
    end

    state_t             state_r;
    logic               out_valid_r;
    logic [OUT_W-1:0]   out_r;
    logic               equality_r;
    logic               balance_r;
    logic               eq_pend_r;
`ifdef SEQ_ALU_ERR_EN
    logic               err_r;
`endif

    logic               accept_s;
    logic               is_mul_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] mul_product_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [OUT_W-1:0]   res_s;
    logic               res_err_s;
    logic               res_bal_s;

    // Handshake: a held result frees the input side only when the sink takes it this cycle.
    always_comb begin
        in_ready = (state_r == IDLE) || ((state_r == DONE) && out_ready);
        accept_s = in_valid && in_ready;
        is_mul_s = (control == OP_MUL);
    end

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept_s && is_mul_s),
        .a       (in1),
        .b       (in2),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Single-cycle ops; an illegal word either flags err or replays the held result.
    always_comb begin
        sum_s     = {1'b0, in1} + {1'b0, in2};
        diff_s    = {1'b0, in1} - {1'b0, in2};
        res_s     = {OUT_W{1'b0}};
        res_err_s = 1'b0;
        case (control)
            OP_ADD:  res_s = OUT_W'(sum_s);
            OP_SUB:  res_s = {{(OUT_W-WIDTH-1){diff_s[WIDTH]}}, diff_s};
            OP_MUL:  res_s = {OUT_W{1'b0}};
            OP_ONES: res_s = OUT_W'(popcount(64'({in1, in2})));
            OP_XOR:  res_s = OUT_W'(in1 ^ in2);
            OP_MAX:  res_s = (in1 > in2) ? OUT_W'(in1) : OUT_W'(in2);
            default: begin
`ifdef SEQ_ALU_ERR_EN
                res_s     = {OUT_W{1'b0}};
                res_err_s = 1'b1;
`else
                res_s     = out_r;
`endif
            end
        endcase
        res_bal_s = res_err_s ? 1'b0 : ~^res_s;
    end

    // Control FSM and result registers; an accept always takes priority over the state's own move.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            out_r       <= {OUT_W{1'b0}};
            equality_r  <= 1'b0;
            balance_r   <= 1'b0;
            eq_pend_r   <= 1'b0;
`ifdef SEQ_ALU_ERR_EN
            err_r       <= 1'b0;
`endif
        end else if (accept_s) begin
            if (is_mul_s) begin
                state_r     <= EXEC;
                out_valid_r <= 1'b0;
                eq_pend_r   <= (in1 == in2);
            end else begin
                state_r     <= DONE;
                out_valid_r <= 1'b1;
                out_r       <= res_s;
                equality_r  <= (in1 == in2);
                balance_r   <= res_bal_s;
`ifdef SEQ_ALU_ERR_EN
                err_r       <= res_err_s;
`endif
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                EXEC: begin
                    if (mul_done_s) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        out_r       <= OUT_W'(mul_product_s);
                        equality_r  <= eq_pend_r;
                        balance_r   <= ~^mul_product_s;
`ifdef SEQ_ALU_ERR_EN
                        err_r       <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign equality  = equality_r;
    assign balance   = balance_r;
`ifdef SEQ_ALU_ERR_EN
    assign err       = err_r;
`endif

endmodule
